// File: rtl/bp_pkg.sv
// Shared types, default geometry and helpers for the dynamic branch predictor.
package bp_pkg;

  localparam int BP_XLEN     = 32;
  localparam int BP_ENTRIES  = 64;
  localparam int BP_TAG_BITS = 8;
  localparam int BP_CTR_BITS = 2;

  localparam int IDX_BITS = $clog2(BP_ENTRIES);
  localparam logic [BP_CTR_BITS-1:0] WT  = BP_CTR_BITS'(1) << (BP_CTR_BITS - 1);
  localparam logic [BP_CTR_BITS-1:0] WNT = WT - BP_CTR_BITS'(1);

  typedef struct packed {
    logic                   valid;
    logic [BP_TAG_BITS-1:0] tag;
    logic [BP_XLEN-1:0]     target;
    logic [BP_CTR_BITS-1:0] ctr;
  } bp_entry_t;

  // Wrong direction, or right "taken" direction with the wrong target.
  function automatic logic bp_mispredict(input logic pred_taken,
                                         input logic taken,
                                         input logic target_eq);
    return (pred_taken != taken) || (taken && pred_taken && !target_eq);
  endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Next-state logic for a saturating up/down direction counter.
module bp_sat_ctr #(
  parameter int CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] ctr_i,
  input  logic                up_i,
  output logic [CTR_BITS-1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (up_i) begin
      if (!(&ctr_i)) ctr_o = ctr_i + CTR_BITS'(1);
    end else if (|ctr_i) begin
      ctr_o = ctr_i - CTR_BITS'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped tagged branch predictor: combinational lookup for fetch,
// one-entry-per-cycle training from execute, plus branch/mispredict counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN     = BP_XLEN,
  parameter int ENTRIES  = BP_ENTRIES,
  parameter int TAG_BITS = BP_TAG_BITS,
  parameter int CTR_BITS = BP_CTR_BITS
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - CTR_BITS'(1);

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [XLEN-1:0]     target;
    logic [CTR_BITS-1:0] ctr;
  } entry_t;

  entry_t table_q [ENTRIES];

  logic [IDX_W-1:0]    lk_idx, up_idx;
  logic [TAG_BITS-1:0] lk_tag, up_tag;
  entry_t              lk_entry, up_entry, entry_d;
  logic                up_hit, misp;
  logic [CTR_BITS-1:0] ctr_step;
  logic [31:0]         branch_count_q, branch_count_d;
  logic [31:0]         mispredict_count_q, mispredict_count_d;

  // Only the index and tag fields of each PC take part in the lookup.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc, upd_pc};

  assign lk_idx   = lookup_pc[IDX_W+1:2];
  assign lk_tag   = lookup_pc[IDX_W+2 +: TAG_BITS];
  assign lk_entry = table_q[lk_idx];

  assign pred_hit    = lk_entry.valid && (lk_entry.tag == lk_tag);
  assign pred_taken  = pred_hit && lk_entry.ctr[CTR_BITS-1];
  assign pred_target = pred_taken ? lk_entry.target : lookup_pc + XLEN'(4);

  assign up_idx   = upd_pc[IDX_W+1:2];
  assign up_tag   = upd_pc[IDX_W+2 +: TAG_BITS];
  assign up_entry = table_q[up_idx];
  assign up_hit   = up_entry.valid && (up_entry.tag == up_tag);

  bp_sat_ctr #(.CTR_BITS(CTR_BITS)) u_sat_ctr (
    .ctr_i (up_entry.ctr),
    .up_i  (upd_taken),
    .ctr_o (ctr_step)
  );

  // A miss allocates fresh, evicting whatever branch shared the index.
  always_comb begin
    entry_d = up_entry;
    if (up_hit) begin
      entry_d.ctr = ctr_step;
      if (upd_taken) entry_d.target = upd_target;
    end else begin
      entry_d.valid  = 1'b1;
      entry_d.tag    = up_tag;
      entry_d.target = upd_target;
      entry_d.ctr    = upd_taken ? CTR_WT : CTR_WNT;
    end
  end

  assign misp = bp_mispredict(upd_pred_taken, upd_taken, upd_pred_target == upd_target);
  assign branch_count_d     = branch_count_q + 32'd1;
  assign mispredict_count_d = mispredict_count_q + {31'b0, misp};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
      end
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else if (upd_valid) begin
      table_q[up_idx]    <= entry_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: per-cycle comparison against an
// abstract table model, plus hand-computed expectations at key points.
module tb_branch_predictor;

  localparam int ENTRIES = 64;
  localparam int TAGMOD  = 256;
  localparam int CMAX    = 3;
  localparam int WTV     = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] lookup_pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic [31:0] branch_count, mispredict_count;

  branch_predictor dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .lookup_pc        (lookup_pc),
    .pred_hit         (pred_hit),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_pred_taken   (upd_pred_taken),
    .upd_pred_target  (upd_pred_target),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  // Abstract model: one record per slot, counter kept as a plain integer.
  bit          m_valid [ENTRIES];
  int          m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int unsigned m_bc, m_mc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_tgt[i]   = '0;
      m_ctr[i]   = WTV - 1;
    end
    m_bc = 0;
    m_mc = 0;
  endtask

  function automatic int slot_of(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'((pc / (4 * ENTRIES)) % TAGMOD);
  endfunction

  task automatic model_pred(input logic [31:0] pc, output logic hit, output logic tk,
                            output logic [31:0] tgt);
    int s;
    s   = slot_of(pc);
    hit = m_valid[s] && (m_tag[s] == tag_of(pc));
    tk  = hit && (m_ctr[s] >= WTV);
    tgt = tk ? m_tgt[s] : pc + 32'd4;
  endtask

  task automatic model_update();
    int s;
    s = slot_of(upd_pc);
    m_bc++;
    if (upd_taken != upd_pred_taken) m_mc++;
    else if (upd_taken && (upd_target != upd_pred_target)) m_mc++;
    if (m_valid[s] && m_tag[s] == tag_of(upd_pc)) begin
      if (upd_taken) begin
        m_ctr[s] = (m_ctr[s] + 1 > CMAX) ? CMAX : m_ctr[s] + 1;
        m_tgt[s] = upd_target;
      end else begin
        m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
      end
    end else begin
      m_valid[s] = 1'b1;
      m_tag[s]   = tag_of(upd_pc);
      m_tgt[s]   = upd_target;
      m_ctr[s]   = upd_taken ? WTV : WTV - 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n && upd_valid) model_update();
    #1;
  endtask

  always @(negedge clk) begin
    logic        eh, et;
    logic [31:0] eg;
    if (chk_en) begin
      model_pred(lookup_pc, eh, et, eg);
      chk("cyc_hit", 32'(pred_hit), 32'(eh));
      chk("cyc_taken", 32'(pred_taken), 32'(et));
      chk("cyc_target", pred_target, eg);
      chk("cyc_branch_count", branch_count, m_bc);
      chk("cyc_mispredict_count", mispredict_count, m_mc);
    end
  end

  task automatic do_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                        input logic ptk, input logic [31:0] ptgt);
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_taken       = tk;
    upd_target      = tgt;
    upd_pred_taken  = ptk;
    upd_pred_target = ptgt;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic expect_pred(input string name, input logic [31:0] pc, input logic hit,
                             input logic tk, input logic [31:0] tgt);
    lookup_pc = pc;
    #1;
    chk({name, "_hit"}, 32'(pred_hit), 32'(hit));
    chk({name, "_taken"}, 32'(pred_taken), 32'(tk));
    chk({name, "_target"}, pred_target, tgt);
  endtask

  task automatic expect_cnt(input string name, input logic [31:0] bc, input logic [31:0] mc);
    chk({name, "_branch_count"}, branch_count, bc);
    chk({name, "_mispredict_count"}, mispredict_count, mc);
  endtask

  initial begin
    reset_n = 1'b1;
    upd_valid = 1'b0;
    upd_pc = '0;
    upd_taken = 1'b0;
    upd_target = '0;
    upd_pred_taken = 1'b0;
    upd_pred_target = '0;
    lookup_pc = 32'h100;
    model_reset();
    #1 reset_n = 1'b0;
    #1;

    expect_pred("rst", 32'h100, 1'b0, 1'b0, 32'h104);
    expect_cnt("rst", 32'd0, 32'd0);
    expect_pred("rst_wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
    lookup_pc = 32'h100;
    tick();
    tick();
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Cold allocate as taken, then train down to zero and back up.
    do_upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    expect_pred("alloc", 32'h100, 1'b1, 1'b1, 32'h80);
    expect_cnt("alloc", 32'd1, 32'd1);
    do_upd(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    expect_pred("nt1", 32'h100, 1'b1, 1'b0, 32'h104);
    do_upd(32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
    do_upd(32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
    do_upd(32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
    expect_pred("nt4", 32'h100, 1'b1, 1'b0, 32'h104);
    expect_cnt("nt4", 32'd5, 32'd2);
    do_upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    expect_pred("floor", 32'h100, 1'b1, 1'b0, 32'h104);
    do_upd(32'h100, 1'b1, 32'h90, 1'b0, 32'h104);
    expect_pred("retarget", 32'h100, 1'b1, 1'b1, 32'h90);
    expect_cnt("retarget", 32'd7, 32'd4);
    do_upd(32'h100, 1'b1, 32'h90, 1'b1, 32'h80);
    do_upd(32'h100, 1'b1, 32'h90, 1'b1, 32'h90);
    expect_cnt("tgt_misp", 32'd9, 32'd5);
    do_upd(32'h100, 1'b0, 32'h90, 1'b1, 32'h90);
    expect_pred("ceiling", 32'h100, 1'b1, 1'b1, 32'h90);
    expect_cnt("ceiling", 32'd10, 32'd6);

    // Aliasing slot 0 evicts 0x100; a second slot is populated for the reset test.
    do_upd(32'h100, 1'b1, 32'h90, 1'b1, 32'h90);
    do_upd(32'h3C, 1'b1, 32'h500, 1'b0, 32'h40);
    do_upd(32'h100 + 4 * ENTRIES, 1'b0, 32'h700, 1'b0, 32'h204);
    expect_pred("evicted", 32'h100, 1'b0, 1'b0, 32'h104);
    expect_pred("alias", 32'h200, 1'b1, 1'b0, 32'h204);
    expect_pred("slot15", 32'h3C, 1'b1, 1'b1, 32'h500);
    expect_cnt("alias", 32'd13, 32'd7);

    // Asynchronous reset mid-cycle with an update pending.
    upd_valid       = 1'b1;
    upd_pc          = 32'h3C;
    upd_taken       = 1'b1;
    upd_target      = 32'h600;
    upd_pred_taken  = 1'b0;
    upd_pred_target = 32'h40;
    lookup_pc       = 32'h3C;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_async_hit", 32'(pred_hit), 32'd0);
    chk("rst_async_target", pred_target, 32'h40);
    expect_cnt("rst_async", 32'd0, 32'd0);
    tick();
    upd_valid = 1'b0;
    reset_n   = 1'b1;
    expect_pred("post_rst_15", 32'h3C, 1'b0, 1'b0, 32'h40);
    expect_pred("post_rst_0", 32'h200, 1'b0, 1'b0, 32'h204);
    expect_cnt("post_rst", 32'd0, 32'd0);

    // Same-cycle lookup and update: old state this cycle, new state next.
    lookup_pc       = 32'h200;
    upd_valid       = 1'b1;
    upd_pc          = 32'h200;
    upd_taken       = 1'b1;
    upd_target      = 32'h400;
    upd_pred_taken  = 1'b0;
    upd_pred_target = 32'h204;
    #1;
    chk("same_cyc_hit", 32'(pred_hit), 32'd0);
    chk("same_cyc_target", pred_target, 32'h204);
    tick();
    upd_valid = 1'b0;
    expect_pred("next_cyc", 32'h200, 1'b1, 1'b1, 32'h400);
    expect_cnt("next_cyc", 32'd1, 32'd1);

    tick();
    tick();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the RISC-V core: a direct-mapped table of tagged entries, each holding a saturating direction counter and a branch target. The fetch stage queries it combinationally with the current PC to steer the next fetch. The execute stage writes back resolved branch outcomes one cycle later. It replaces the core's static not-taken assumption and adds branch and misprediction performance counters.

## Interface
- `XLEN`, 32, PC and target width
- `ENTRIES`, 64, table depth; power of two, ≥ 2
- `TAG_BITS`, 8, tag width; requires 2 + log2(ENTRIES) + TAG_BITS ≤ XLEN
- `CTR_BITS`, 2, direction counter width, ≥ 1
- `clk` in 1: single clock, all state updates on its rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `lookup_pc` in XLEN: fetch PC
- `pred_hit` out 1: valid entry with matching tag
- `pred_taken` out 1: predicted taken
- `pred_target` out XLEN: predicted target; `lookup_pc + 4` when not `pred_taken`
- `upd_valid` in 1: resolved conditional branch this cycle
- `upd_pc` in XLEN: PC of resolved branch
- `upd_taken` in 1: actual direction
- `upd_target` in XLEN: actual taken target
- `upd_pred_taken` in 1: direction fetch used for this branch
- `upd_pred_target` in XLEN: target fetch used for this branch
- `branch_count` out 32: resolved branches
- `mispredict_count` out 32: mispredicted branches

## Operation
- Index = `pc[log2(ENTRIES)+1:2]`. Tag = the next TAG_BITS bits above the index.
- Entry fields: `valid`, `tag`, `target`, `ctr[CTR_BITS]`.
- WT = 1<<(CTR_BITS-1). WNT = WT-1 (0 when CTR_BITS = 1).
- Lookup is purely combinational:
  - `pred_hit` = valid && tag match.
  - `pred_taken` = `pred_hit` && ctr MSB.
  - `pred_target` = entry target if `pred_taken`, else `lookup_pc + 4` (mod 2^XLEN).
- Update on `upd_valid` at the clock edge.
  - Hit: ctr increments if taken, decrements if not. It saturates at all-ones and at 0. Target is overwritten only when taken.
  - Miss: entry is allocated, overwriting any previous occupant. Sets valid = 1, tag, target = `upd_target`, ctr = WT if taken else WNT.
- Misprediction = `upd_pred_taken != upd_taken`, or (both taken and `upd_pred_target != upd_target`).
- On `upd_valid`, `branch_count` increments; `mispredict_count` also increments on misprediction.
- Both performance counters wrap modulo 2^32.

## Timing
- Lookup latency 0 cycles; update visible to lookups from the cycle after the edge.
- Simultaneous lookup and update of the same index: lookup returns pre-update state; no bypass.
- `upd_valid` low: no table or counter change; update inputs are don't-care.
- Reset (asynchronous assert, any cycle, including mid-update): all valid bits cleared, all ctr set to WNT, targets and tags zeroed, both counters 0.
- Consequences of reset: outputs immediately read `pred_hit` = 0, `pred_taken` = 0, `pred_target` = `lookup_pc + 4`. An update coincident with reset is discarded.
- First edge after `reset_n` rises performs normal updates.

## Structure
- Package `bp_pkg`: entry struct typedef (valid/tag/target/ctr); localparams IDX_BITS, WT, WNT; a misprediction-check function.
- Sub-module `bp_sat_ctr`: CTR_BITS-wide saturating up/down next-state logic, instantiated once on the update path.
- Table is a register array, reset asynchronously; no SRAM macro at this size.

## Test plan
- Reset, then `lookup_pc` = 0x100 -> `pred_hit` = 0, `pred_taken` = 0, `pred_target` = 0x104; both counters 0.
- Update pc = 0x100, taken, target 0x80, pred_taken = 0 -> next cycle lookup 0x100 gives hit, taken, target 0x80; `branch_count` = 1, `mispredict_count` = 1.
- Then four not-taken updates of 0x100 (CTR_BITS = 2) -> ctr 2→1→0→0→0. Taken prediction drops after the first update; counter saturates at 0 with no underflow.
- Alias: update 0x100 taken, then update 0x100 + 4·ENTRIES not-taken -> 0x100 now misses; the alias hits with `pred_taken` = 0.
- Same-cycle lookup and update of 0x200 from cold -> miss during that cycle, hit the next.
- Assert `reset_n` low mid-run with table populated and counters nonzero, coincident with `upd_valid` -> all lookups miss; counters read 0 immediately and after release.
